// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// IF/ID update actions, reset/bubble constants and the PC step.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // What the IF/ID register does on the coming edge
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } ifid_act_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'h0000_0004;

  // A redirect target is usable only when it is word aligned
  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus between the fetch stage, the instruction ROM and the decode stage.
// master = fetch stage, slave = ROM/decode side.
interface inst_fetch_if;

  logic [31:0] instruction;
  logic [31:0] instAddr;
  logic        romCe;
  logic        stall;
  logic        flush;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic        idValid;
  logic        fetchErr;

  modport master (
    input  instruction, stall, flush, branchFlag, branchTarget,
    output instAddr, romCe, idPc, idInst, idValid, fetchErr
  );

  modport slave (
    output instruction, stall, flush, branchFlag, branchTarget,
    input  instAddr, romCe, idPc, idInst, idValid, fetchErr
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-state / next-PC / IF/ID action selector.
// Encodes the redirect > flush > stall > advance priority of the RUN state.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  fetch_state_t state,
  input  logic [31:0]  pc,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_flag,
  input  logic [31:0]  branch_target,
  output fetch_state_t next_state,
  output logic [31:0]  next_pc,
  output ifid_act_t    ifid_act,
  output logic         set_err
);

  // Priority decode of the control inputs for the current state
  always_comb begin
    next_state = state;
    next_pc    = pc;
    ifid_act   = ACT_HOLD;
    set_err    = 1'b0;
    case (state)
      ST_BOOT: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (branch_flag && !word_aligned(branch_target[1:0])) begin
          next_state = ST_HALT;
          ifid_act   = ACT_BUBBLE;
          set_err    = 1'b1;
        end else if (branch_flag) begin
          // No delay slot: the word fetched this cycle is squashed
          next_pc  = branch_target;
          ifid_act = ACT_BUBBLE;
        end else if (flush) begin
          // PC held so the current word is fetched again next cycle
          ifid_act = ACT_BUBBLE;
        end else if (stall) begin
          ifid_act = ACT_HOLD;
        end else begin
          next_pc  = pc + PC_INC;
          ifid_act = ACT_LOAD;
        end
      end
      ST_HALT: begin
        ifid_act = ACT_BUBBLE;
      end
      default: begin
        next_state = ST_HALT;
        ifid_act   = ACT_BUBBLE;
        set_err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the ROM address/enable and
// captures the returned word into the IF/ID pipeline register.
module inst_fetch
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  fetch_state_t state;
  fetch_state_t next_state;
  logic [31:0]  pc;
  logic [31:0]  next_pc;
  ifid_act_t    ifid_act;
  logic         set_err;
  logic [31:0]  id_pc;
  logic [31:0]  id_inst;
  logic         id_valid;
  logic         fetch_err;

  fetch_next_pc u_next_pc (
    .state         (state),
    .pc            (pc),
    .stall         (bus.stall),
    .flush         (bus.flush),
    .branch_flag   (bus.branchFlag),
    .branch_target (bus.branchTarget),
    .next_state    (next_state),
    .next_pc       (next_pc),
    .ifid_act      (ifid_act),
    .set_err       (set_err)
  );

  // State, PC, IF/ID and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      id_pc     <= 32'h0000_0000;
      id_inst   <= NOP_WORD;
      id_valid  <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= next_pc;
      fetch_err <= fetch_err | set_err;
      case (ifid_act)
        ACT_LOAD: begin
          id_inst  <= bus.instruction;
          id_pc    <= pc;
          id_valid <= 1'b1;
        end
        ACT_BUBBLE: begin
          id_inst  <= NOP_WORD;
          id_pc    <= 32'h0000_0000;
          id_valid <= 1'b0;
        end
        ACT_HOLD: begin
          id_inst  <= id_inst;
          id_pc    <= id_pc;
          id_valid <= id_valid;
        end
        default: begin
          id_inst  <= NOP_WORD;
          id_pc    <= 32'h0000_0000;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; ROM enable decodes the state only
  assign bus.instAddr = pc;
  assign bus.romCe    = (state == ST_RUN);
  assign bus.idPc     = id_pc;
  assign bus.idInst   = id_inst;
  assign bus.idValid  = id_valid;
  assign bus.fetchErr = fetch_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed vectors push hand-computed
// expected snapshots; a negedge monitor pops and compares them.
module tb_inst_fetch;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] addr;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter for tagging expected snapshots
  always @(posedge clk) cyc <= cyc + 1;

  // Instruction ROM model; returns junk when disabled so ignoring it is tested
  always_comb begin
    if (bus.romCe) bus.instruction = bus.instAddr ^ 32'hA5A5_0000;
    else           bus.instruction = 32'hDEAD_BEEF;
  end

  task automatic compare(input string name, input logic [31:0] ea, input logic ece,
                         input logic [31:0] epc, input logic [31:0] ei,
                         input logic ev, input logic ee);
    checks = checks + 1;
    if (bus.instAddr !== ea || bus.romCe !== ece || bus.idPc !== epc ||
        bus.idInst !== ei || bus.idValid !== ev || bus.fetchErr !== ee) begin
      errors = errors + 1;
      $display("FAIL %s: got addr=%h ce=%b pc=%h inst=%h v=%b err=%b want addr=%h ce=%b pc=%h inst=%h v=%b err=%b",
               name, bus.instAddr, bus.romCe, bus.idPc, bus.idInst, bus.idValid, bus.fetchErr,
               ea, ece, epc, ei, ev, ee);
    end
  endtask

  // Monitor: compare every expected snapshot that is due this cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: snapshot for cycle %0d not compared, now cycle %0d", e.name, e.cyc, cyc);
      end else begin
        compare(e.name, e.addr, e.ce, e.pc, e.inst, e.v, e.err);
      end
    end
  end

  // Drive one cycle of inputs and record the state expected after the edge
  task automatic apply(input string name, input logic s, input logic f, input logic b,
                       input logic [31:0] t, input logic [31:0] ea, input logic ece,
                       input logic [31:0] epc, input logic [31:0] ei,
                       input logic ev, input logic ee);
    exp_t e;
    bus.stall        = s;
    bus.flush        = f;
    bus.branchFlag   = b;
    bus.branchTarget = t;
    e.cyc  = cyc + 1;
    e.name = name;
    e.addr = ea;
    e.ce   = ece;
    e.pc   = epc;
    e.inst = ei;
    e.v    = ev;
    e.err  = ee;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.stall        = 1'b0;
    bus.flush        = 1'b0;
    bus.branchFlag   = 1'b0;
    bus.branchTarget = 32'h0000_0000;
    @(posedge clk);
    #1;
    //     name           s     f     b     target         addr           ce    idPc           idInst         v     err
    apply("reset",        1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    rst = 1'b0;
    apply("boot_e0",      1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("fetch_0",      1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b1, 1'b0);
    apply("fetch_4",      1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 1'b0);
    apply("stall_1",      1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 1'b0);
    apply("stall_2",      1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 1'b0);
    apply("stall_3",      1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 1'b0);
    apply("resume_8",     1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_000C, 1'b1, 32'h0000_0008, 32'hA5A5_0008, 1'b1, 1'b0);
    apply("fetch_c",      1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0010, 1'b1, 32'h0000_000C, 32'hA5A5_000C, 1'b1, 1'b0);
    apply("br_all",       1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("br_target",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'h0000_0100, 32'hA5A5_0100, 1'b1, 1'b0);
    apply("flush_stall",  1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0104, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("refetch",      1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'hA5A5_0104, 1'b1, 1'b0);
    apply("br_top",       1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("wrap",         1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1, 1'b0);
    apply("after_wrap",   1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b1, 1'b0);
    apply("br_misalign",  1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    apply("halt_idle",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    apply("halt_branch",  1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    apply("halt_hold",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);

    // Asynchronous reset from HALT, mid-cycle
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    compare("rst_async_halt", 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("rst_held",     1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    rst = 1'b0;
    apply("reboot_e0",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    apply("refetch_0",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b1, 32'h0000_0000, 32'hA5A5_0000, 1'b1, 1'b0);
    apply("refetch_4",    1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b1, 32'h0000_0004, 32'hA5A5_0004, 1'b1, 1'b0);

    // Asynchronous reset while running, mid-cycle
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    compare("rst_async_run", 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d snapshots left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
